// File: rtl/spi_resp_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// spi_resp_pkg: shared types and sizing for the SPI slave responder. Rev 1.0
//------------------------------------------------------------------------------
package spi_resp_pkg;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } state_t;

   localparam int SS_WIDTH     = 8;
   localparam int MAX_CHAR_LEN = 128;

   function automatic int cnt_width(input int max_len);
      return $clog2(max_len + 1);
   endfunction

   localparam int CNT_W = cnt_width(MAX_CHAR_LEN);

endpackage
`default_nettype wire

// File: rtl/spi_resp_sync.sv
`default_nettype none
//------------------------------------------------------------------------------
// spi_resp_sync: multi-flop synchronizer with optional rise/fall detector. Rev 1.0
//------------------------------------------------------------------------------
module spi_resp_sync #(
   parameter int STAGES   = 2,
   parameter bit EDGE_DET = 1'b1
) (
   input  logic clock,
   input  logic reset,
   input  logic d,
   output logic q,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] chain_q;
   logic [STAGES-1:0] chain_d;

   always_comb begin
      chain_d = {chain_q[STAGES-2:0], d};
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         chain_q <= '0;
      end else begin
         chain_q <= chain_d;
      end
   end

   assign q = chain_q[STAGES-1];

   generate
      if (EDGE_DET) begin : g_edge
         logic prev_q;
         always_ff @(posedge clock) begin
            if (reset) begin
               prev_q <= 1'b0;
            end else begin
               prev_q <= q;
            end
         end
         assign rise = q & ~prev_q;
         assign fall = ~q & prev_q;
      end else begin : g_no_edge
         assign rise = 1'b0;
         assign fall = 1'b0;
      end
   endgenerate

endmodule
`default_nettype wire

// File: rtl/spi_slave_responder.sv
`default_nettype none
//------------------------------------------------------------------------------
// spi_slave_responder: oversampled SPI slave with a one-word transmit buffer.
// LSB-first support is built in when SPI_RESP_LSB_EN is defined. Rev 1.0
//------------------------------------------------------------------------------
module spi_slave_responder
   import spi_resp_pkg::*;
#(
   parameter int CHAR_LEN    = 8,
   parameter int SS_INDEX    = 0,
   parameter int SYNC_STAGES = 2
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                sclk_pad_o,
   input  logic                mosi_pad_o,
   input  logic [SS_WIDTH-1:0] ss_pad_o,
   output logic                miso_pad_i,
   input  logic                tx_neg,
   input  logic                rx_neg,
   input  logic [CHAR_LEN-1:0] tx_data,
   input  logic                tx_valid,
   output logic                tx_ready,
   output logic [CHAR_LEN-1:0] rx_data,
   output logic                rx_valid,
   output logic                tx_underrun,
   output logic                busy
`ifdef SPI_RESP_LSB_EN
   ,
   input  logic                lsb
`endif
);

   logic sclk_s, sclk_rise, sclk_fall;
   logic mosi_s, mosi_rise, mosi_fall;
   logic ss_s, ss_rise, ss_fall_nc;
   logic lsb_in;

   spi_resp_sync #(.STAGES(SYNC_STAGES), .EDGE_DET(1'b1)) u_sync_sclk (
      .clock(clock), .reset(reset), .d(sclk_pad_o),
      .q(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
   );
   spi_resp_sync #(.STAGES(SYNC_STAGES), .EDGE_DET(1'b0)) u_sync_mosi (
      .clock(clock), .reset(reset), .d(mosi_pad_o),
      .q(mosi_s), .rise(mosi_rise), .fall(mosi_fall)
   );
   spi_resp_sync #(.STAGES(SYNC_STAGES), .EDGE_DET(1'b0)) u_sync_ss (
      .clock(clock), .reset(reset), .d(ss_pad_o[SS_INDEX]),
      .q(ss_s), .rise(ss_rise), .fall(ss_fall_nc)
   );

   logic unused_inputs;
   assign unused_inputs = &{1'b0, sclk_s, mosi_rise, mosi_fall, ss_rise, ss_fall_nc, ss_pad_o};

`ifdef SPI_RESP_LSB_EN
   assign lsb_in = lsb;
`else
   assign lsb_in = 1'b0;
`endif

   state_t              state_q, state_d;
   logic [CHAR_LEN-1:0] tx_sr_q, tx_sr_d, rx_sr_q, rx_sr_d;
   logic [CHAR_LEN-1:0] rx_data_q, rx_data_d, buf_q, buf_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                buf_full_q, buf_full_d, sampled_q, sampled_d;
   logic                miso_q, miso_d, rx_valid_q, rx_valid_d;
   logic                underrun_q, underrun_d, ss_prev_q, lsb_q, lsb_d;

   logic                ss_fall, sample_edge, drive_edge, do_load;
   logic [CHAR_LEN-1:0] load_word, rx_next, tx_shift;

   assign ss_fall     = ss_prev_q & ~ss_s;
   assign sample_edge = tx_neg ? sclk_rise : sclk_fall;
   assign drive_edge  = rx_neg ? sclk_rise : sclk_fall;

   always_comb begin
      state_d    = state_q;
      tx_sr_d    = tx_sr_q;
      rx_sr_d    = rx_sr_q;
      rx_data_d  = rx_data_q;
      buf_d      = buf_q;
      buf_full_d = buf_full_q;
      cnt_d      = cnt_q;
      sampled_d  = sampled_q;
      miso_d     = miso_q;
      lsb_d      = lsb_q;
      rx_valid_d = 1'b0;
      underrun_d = 1'b0;
      do_load    = 1'b0;

      // Buffer has priority, then a same-cycle bypass of tx_data, else zeros.
      if (buf_full_q) begin
         load_word = buf_q;
      end else if (tx_valid) begin
         load_word = tx_data;
      end else begin
         load_word = '0;
      end

      if (lsb_q) begin
         rx_next = rx_sr_q >> 1;
         rx_next[CHAR_LEN-1] = mosi_s;
         tx_shift = tx_sr_q >> 1;
      end else begin
         rx_next = rx_sr_q << 1;
         rx_next[0] = mosi_s;
         tx_shift = tx_sr_q << 1;
      end

      case (state_q)
         IDLE: begin
            if (ss_fall) begin
               state_d = ACTIVE;
               cnt_d   = '0;
               rx_sr_d = '0;
               do_load = 1'b1;
            end
         end
         ACTIVE: begin
            if (ss_s) begin
               state_d   = IDLE;
               cnt_d     = '0;
               sampled_d = 1'b0;
               miso_d    = 1'b0;
            end else if (sample_edge) begin
               rx_sr_d   = rx_next;
               sampled_d = 1'b1;
               if (cnt_q == CNT_W'(CHAR_LEN - 1)) begin
                  rx_data_d  = rx_next;
                  rx_valid_d = 1'b1;
                  cnt_d      = '0;
                  do_load    = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end else if (drive_edge && sampled_q) begin
               tx_sr_d = tx_shift;
               miso_d  = lsb_q ? tx_shift[0] : tx_shift[CHAR_LEN-1];
            end
         end
         default: state_d = IDLE;
      endcase

      if (do_load) begin
         lsb_d     = lsb_in;
         tx_sr_d   = load_word;
         miso_d    = lsb_in ? load_word[0] : load_word[CHAR_LEN-1];
         sampled_d = 1'b0;
         if (buf_full_q) begin
            buf_full_d = 1'b0;
         end else if (!tx_valid) begin
            underrun_d = 1'b1;
         end
      end else if (tx_valid && !buf_full_q) begin
         buf_d      = tx_data;
         buf_full_d = 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= IDLE;
         tx_sr_q    <= '0;
         rx_sr_q    <= '0;
         rx_data_q  <= '0;
         buf_q      <= '0;
         buf_full_q <= 1'b0;
         cnt_q      <= '0;
         sampled_q  <= 1'b0;
         miso_q     <= 1'b0;
         lsb_q      <= 1'b0;
         rx_valid_q <= 1'b0;
         underrun_q <= 1'b0;
         ss_prev_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         tx_sr_q    <= tx_sr_d;
         rx_sr_q    <= rx_sr_d;
         rx_data_q  <= rx_data_d;
         buf_q      <= buf_d;
         buf_full_q <= buf_full_d;
         cnt_q      <= cnt_d;
         sampled_q  <= sampled_d;
         miso_q     <= miso_d;
         lsb_q      <= lsb_d;
         rx_valid_q <= rx_valid_d;
         underrun_q <= underrun_d;
         ss_prev_q  <= ss_s;
      end
   end

   assign miso_pad_i  = miso_q;
   assign tx_ready    = ~buf_full_q;
   assign rx_data     = rx_data_q;
   assign rx_valid    = rx_valid_q;
   assign tx_underrun = underrun_q;
   assign busy        = (state_q == ACTIVE);

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_responder.sv
`default_nettype none
//------------------------------------------------------------------------------
// tb_spi_slave_responder: SPI master model driving the responder, queue-based
// model of the transmit words it should return. Rev 1.0
//------------------------------------------------------------------------------
module tb_spi_slave_responder;

   localparam int CHAR_LEN    = 8;
   localparam int SS_INDEX    = 3;
   localparam int SYNC_STAGES = 2;
   localparam int HALF        = 2 * SYNC_STAGES + 6;
   localparam int SETUP       = SYNC_STAGES + 6;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       sclk = 1'b0, mosi = 1'b0, miso;
   logic [7:0] ss_pad = 8'hFF;
   logic       tx_neg = 1'b1, rx_neg = 1'b0;
   logic [7:0] tx_data = 8'h00, rx_data;
   logic       tx_valid = 1'b0, tx_ready, rx_valid, tx_underrun, busy;
   logic       lsb = 1'b0;

   spi_slave_responder #(
      .CHAR_LEN(CHAR_LEN), .SS_INDEX(SS_INDEX), .SYNC_STAGES(SYNC_STAGES)
   ) dut (
      .clock(clock), .reset(reset), .sclk_pad_o(sclk), .mosi_pad_o(mosi),
      .ss_pad_o(ss_pad), .miso_pad_i(miso), .tx_neg(tx_neg), .rx_neg(rx_neg),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .tx_underrun(tx_underrun),
      .busy(busy)
`ifdef SPI_RESP_LSB_EN
      , .lsb(lsb)
`endif
   );

   always #5 clock = ~clock;

   int         checks = 0;
   int         errors = 0;
   int         underruns = 0;
   int         exp_under = 0;
   logic [7:0] rx_log[$];
   logic [7:0] model_q[$];
   logic [7:0] cur_exp = 8'h00;

   always @(negedge clock) begin
      if (rx_valid) rx_log.push_back(rx_data);
      if (tx_underrun) underruns++;
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic set_ss(input logic v);
      ss_pad = 8'($urandom);
      ss_pad[SS_INDEX] = v;
   endtask

   // A character boundary hands out the oldest buffered word, or zeros.
   task automatic model_load();
      if (model_q.size() != 0) cur_exp = model_q.pop_front();
      else begin
         cur_exp = 8'h00;
         exp_under++;
      end
   endtask

   task automatic write_tx(input logic [7:0] w);
      int t = 0;
      while (!tx_ready && t < 100) begin
         tick(1);
         t++;
      end
      checks++;
      if (tx_ready !== 1'b1) begin
         errors++;
         $display("FAIL write_tx_timeout tx_ready=%b want 1", tx_ready);
      end else begin
         tx_data = w; tx_valid = 1'b1;
         tick(1);
         tx_valid = 1'b0;
         model_q.push_back(w);
      end
   endtask

   task automatic ss_assert();
      set_ss(1'b0);
      tick(SETUP);
      model_load();
   endtask

   task automatic ss_deassert();
      tick(HALF);
      set_ss(1'b1);
      tick(SETUP);
   endtask

   // Master side of one character; tx_neg selects which sclk edge carries MOSI.
   task automatic xfer_char(input logic [7:0] mo, input int nbits, input bit lsbf,
                            output logic [7:0] mi, output logic [7:0] exp,
                            output int npulse, output logic [7:0] rxw);
      int n0;
      n0 = rx_log.size();
      exp = cur_exp;
      mi = 8'h00;
      for (int i = 0; i < nbits; i++) begin
         int b;
         b = lsbf ? i : 7 - i;
         set_ss(ss_pad[SS_INDEX]);
         if (tx_neg) begin
            mosi = mo[b];
            tick(HALF);
            mi[b] = miso;
            sclk = 1'b1;
            tick(HALF);
            sclk = 1'b0;
         end else begin
            sclk = 1'b1;
            mosi = mo[b];
            tick(HALF);
            mi[b] = miso;
            sclk = 1'b0;
            tick(HALF);
         end
      end
      if (nbits == CHAR_LEN) model_load();
      npulse = rx_log.size() - n0;
      rxw = (npulse > 0) ? rx_log[rx_log.size()-1] : 8'h00;
   endtask

   logic [7:0] mi, e, rw, w, mo;
   int         np, u0;

   task automatic test_reset();
      reset = 1'b1;
      tick(4);
      checks++; if (miso !== 1'b0) begin errors++; $display("FAIL rst_miso got %b want 0", miso); end
      checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL rst_tx_ready got %b want 1", tx_ready); end
      checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL rst_rx_data got %h want 00", rx_data); end
      checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL rst_rx_valid got %b want 0", rx_valid); end
      checks++; if (tx_underrun !== 1'b0) begin errors++; $display("FAIL rst_underrun got %b want 0", tx_underrun); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
      reset = 1'b0;
      tick(2);
   endtask

   task automatic test_basic();
      tx_neg = 1'b1; rx_neg = 1'b0;
      write_tx(8'hA5);
      ss_assert();
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy got %b want 1", busy); end
      xfer_char(8'h3C, 8, 1'b0, mi, e, np, rw);
      checks++; if (mi !== 8'hA5) begin errors++; $display("FAIL basic_miso got %h want a5", mi); end
      checks++; if (np != 1) begin errors++; $display("FAIL basic_rx_pulses got %0d want 1", np); end
      checks++; if (rw !== 8'h3C) begin errors++; $display("FAIL basic_rx_data got %h want 3c", rw); end
      ss_deassert();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_idle got %b want 0", busy); end
   endtask

   task automatic test_back_to_back();
      write_tx(8'h11);
      ss_assert();
      checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready0 got %b want 1", tx_ready); end
      write_tx(8'h22);
      xfer_char(8'hF0, 8, 1'b0, mi, e, np, rw);
      checks++; if (mi !== 8'h11) begin errors++; $display("FAIL b2b_miso0 got %h want 11", mi); end
      checks++; if (np != 1 || rw !== 8'hF0) begin errors++; $display("FAIL b2b_rx0 got %0d/%h want 1/f0", np, rw); end
      checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready1 got %b want 1", tx_ready); end
      xfer_char(8'h0F, 8, 1'b0, mi, e, np, rw);
      checks++; if (mi !== 8'h22) begin errors++; $display("FAIL b2b_miso1 got %h want 22", mi); end
      checks++; if (np != 1 || rw !== 8'h0F) begin errors++; $display("FAIL b2b_rx1 got %0d/%h want 1/0f", np, rw); end
      ss_deassert();
   endtask

   task automatic test_underrun();
      u0 = underruns;
      ss_assert();
      checks++; if (underruns - u0 != 1) begin errors++; $display("FAIL und_pulse got %0d want 1", underruns - u0); end
      mo = 8'($urandom);
      xfer_char(mo, 8, 1'b0, mi, e, np, rw);
      checks++; if (mi !== 8'h00) begin errors++; $display("FAIL und_miso got %h want 00", mi); end
      checks++; if (rw !== mo) begin errors++; $display("FAIL und_rx got %h want %h", rw, mo); end
      ss_deassert();
   endtask

   task automatic test_abort();
      int n0;
      write_tx(8'($urandom));
      ss_assert();
      n0 = rx_log.size();
      xfer_char(8'($urandom), 5, 1'b0, mi, e, np, rw);
      ss_deassert();
      checks++; if (miso !== 1'b0) begin errors++; $display("FAIL abort_miso got %b want 0", miso); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
      checks++; if (rx_log.size() != n0) begin errors++; $display("FAIL abort_rx_valid got %0d want %0d", rx_log.size(), n0); end
      write_tx(8'($urandom));
      ss_assert();
      xfer_char(8'h81, 8, 1'b0, mi, e, np, rw);
      checks++; if (mi !== e) begin errors++; $display("FAIL abort_next_miso got %h want %h", mi, e); end
      checks++; if (rw !== 8'h81) begin errors++; $display("FAIL abort_next_rx got %h want 81", rw); end
      ss_deassert();
   endtask

   task automatic test_reset_mid();
      int n0;
      write_tx(8'($urandom));
      ss_assert();
      xfer_char(8'($urandom), 2, 1'b0, mi, e, np, rw);
      mosi = 1'b1;
      tick(HALF / 2);
      reset = 1'b1;
      tick(3);
      checks++; if (miso !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rmid_miso_busy got %b%b want 00", miso, busy); end
      checks++; if (rx_data !== 8'h00 || tx_ready !== 1'b1) begin errors++; $display("FAIL rmid_rx_ready got %h/%b want 00/1", rx_data, tx_ready); end
      reset = 1'b0;
      model_q.delete();
      n0 = rx_log.size();
      u0 = underruns;
      xfer_char(8'($urandom), 7, 1'b0, mi, e, np, rw);
      checks++; if (rx_log.size() != n0 || underruns != u0) begin errors++; $display("FAIL rmid_quiet got %0d/%0d want %0d/%0d", rx_log.size(), underruns, n0, u0); end
      checks++; if (busy !== 1'b0 || miso !== 1'b0) begin errors++; $display("FAIL rmid_idle got %b%b want 00", busy, miso); end
      ss_deassert();
      write_tx(8'($urandom));
      ss_assert();
      mo = 8'($urandom);
      xfer_char(mo, 8, 1'b0, mi, e, np, rw);
      checks++; if (mi !== e || rw !== mo) begin errors++; $display("FAIL rmid_after got %h/%h want %h/%h", mi, rw, e, mo); end
      ss_deassert();
   endtask

   task automatic test_random();
      for (int it = 0; it < 8; it++) begin
         int nch;
         tx_neg = 1'($urandom_range(0, 1));
         rx_neg = ~tx_neg;
         if ($urandom_range(0, 1) == 1) write_tx(8'($urandom));
         ss_assert();
         nch = $urandom_range(1, 3);
         for (int c = 0; c < nch; c++) begin
            if ($urandom_range(0, 1) == 1) write_tx(8'($urandom));
            mo = 8'($urandom);
            xfer_char(mo, 8, 1'b0, mi, e, np, rw);
            checks++; if (mi !== e) begin errors++; $display("FAIL rand_miso it%0d c%0d got %h want %h", it, c, mi, e); end
            checks++; if (np != 1 || rw !== mo) begin errors++; $display("FAIL rand_rx it%0d c%0d got %0d/%h want 1/%h", it, c, np, rw, mo); end
         end
         ss_deassert();
      end
      tx_neg = 1'b1; rx_neg = 1'b0;
      checks++; if (underruns != exp_under) begin errors++; $display("FAIL underrun_total got %0d want %0d", underruns, exp_under); end
   endtask

`ifdef SPI_RESP_LSB_EN
   task automatic test_lsb();
      lsb = 1'b1;
      w = 8'($urandom);
      write_tx(w);
      ss_assert();
      xfer_char(8'h01, 8, 1'b1, mi, e, np, rw);
      checks++; if (mi[0] !== w[0] || mi !== w) begin errors++; $display("FAIL lsb_miso got %h want %h", mi, w); end
      checks++; if (rw !== 8'h01) begin errors++; $display("FAIL lsb_rx got %h want 01", rw); end
      ss_deassert();
      lsb = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_underrun();
      test_abort();
      test_reset_mid();
      test_random();
`ifdef SPI_RESP_LSB_EN
      test_lsb();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
